// File: rtl/i2c_pin_conditioner.sv
// SCL/SDA pad front end: 2-flop sync, programmable glitch filter, START/STOP detect, bus-busy.
// Optional SCL-stuck-low timeout enabled by defining I2C_TIMEOUT_EN.
module i2c_pin_conditioner #(
    parameter int FILT_W = 4,
    parameter int TMO_W  = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              scl_pad_i,
    input  logic              sda_pad_i,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              scl_f,
    output logic              sda_f,
    output logic              start_det,
    output logic              stop_det,
    output logic              bus_busy,
    output logic              scl_stuck
);

    logic [1:0]        scl_sync, sda_sync;
    logic [FILT_W-1:0] scl_cnt, sda_cnt;
    logic              scl_q, sda_q;
    logic              start_c, stop_c;

    // Reset to 1 so the idle-high bus produces no edges after reset
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_cnt <= '0;
            scl_f   <= 1'b1;
        end else if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt >= filt_len) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sda_cnt <= '0;
            sda_f   <= 1'b1;
        end else if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt >= filt_len) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + FILT_W'(1);
        end
    end

    // SCL must be high on both sides of the SDA edge; a simultaneous SCL change masks it
    assign start_c = sda_q & ~sda_f & scl_q & scl_f;
    assign stop_c  = ~sda_q & sda_f & scl_q & scl_f;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= scl_f;
            sda_q     <= sda_f;
            start_det <= start_c;
            stop_det  <= stop_c;
        end
    end

`ifdef I2C_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W:0]   tmo_nxt;
    logic             tmo_run, tmo_hit;

    assign tmo_run = bus_busy && !scl_f && (tmo_limit != '0);
    assign tmo_nxt = {1'b0, tmo_cnt} + (TMO_W+1)'(1);
    // Compare against the post-increment value so the hit lands on the same edge as the count
    assign tmo_hit = tmo_run && (tmo_nxt >= {1'b0, tmo_limit});

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (!tmo_run) begin
            tmo_cnt <= '0;
        end else if (tmo_hit) begin
            tmo_cnt <= tmo_limit;
        end else begin
            tmo_cnt <= tmo_nxt[TMO_W-1:0];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_stuck <= 1'b0;
        end else if (scl_f) begin
            scl_stuck <= 1'b0;
        end else if (tmo_hit) begin
            scl_stuck <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus_busy <= 1'b0;
        end else if (tmo_hit) begin
            bus_busy <= 1'b0;
        end else if (start_det) begin
            bus_busy <= 1'b1;
        end else if (stop_det) begin
            bus_busy <= 1'b0;
        end
    end
`else
    logic tmo_limit_unused;

    assign tmo_limit_unused = ^tmo_limit;
    assign scl_stuck        = 1'b0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus_busy <= 1'b0;
        end else if (start_det) begin
            bus_busy <= 1'b1;
        end else if (stop_det) begin
            bus_busy <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_pin_conditioner.sv
// Bench for i2c_pin_conditioner: expected START/STOP pulses are queued with their
// predicted cycle as stimulus is driven, then matched against pulses seen on the DUT.
module tb_i2c_pin_conditioner;

    localparam int FILT_W = 4;
    localparam int TMO_W  = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              scl_pad_i;
    logic              sda_pad_i;
    logic [FILT_W-1:0] filt_len;
    logic [TMO_W-1:0]  tmo_limit;
    logic              scl_f, sda_f, start_det, stop_det, bus_busy, scl_stuck;

    typedef struct {
        int kind;   // 1 = START, 2 = STOP
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    i2c_pin_conditioner #(.FILT_W(FILT_W), .TMO_W(TMO_W)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .scl_pad_i (scl_pad_i),
        .sda_pad_i (sda_pad_i),
        .filt_len  (filt_len),
        .tmo_limit (tmo_limit),
        .scl_f     (scl_f),
        .sda_f     (sda_f),
        .start_det (start_det),
        .stop_det  (stop_det),
        .bus_busy  (bus_busy),
        .scl_stuck (scl_stuck)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    // Pulse monitor: records every detect pulse with the number of rising edges so far
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (start_det) obs_q.push_back('{1, cyc});
            if (stop_det)  obs_q.push_back('{2, cyc});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic test_reset;
        ev_t e, o;
        PRESETn   = 1'b0;
        scl_pad_i = 1'b1;
        sda_pad_i = 1'b1;
        filt_len  = '0;
        tmo_limit = '0;
        exp_q.delete();
        obs_q.delete();
        step(3);
        n_cmp++;
        if ({scl_f, sda_f, start_det, stop_det, bus_busy, scl_stuck} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_held: outputs %b, required 110000",
                     {scl_f, sda_f, start_det, stop_det, bus_busy, scl_stuck});
        end
        PRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if ({scl_f, sda_f, start_det, stop_det, bus_busy, scl_stuck} !== 6'b110000) begin
                n_err++;
                $display("FAIL reset_idle_%0d: outputs %b, required 110000", i,
                         {scl_f, sda_f, start_det, stop_det, bus_busy, scl_stuck});
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_pulses: %0d pulses seen, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch_filter;
        ev_t e, o;
        int  low_seen, fall_cyc, c0;
        filt_len = 4'd3;
        exp_q.delete();
        obs_q.delete();
        step(2);
        // 3-cycle low glitch: rejected
        sda_pad_i = 1'b0;
        low_seen  = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            if (!sda_f) low_seen = 1;
            if (i == 3) sda_pad_i = 1'b1;
        end
        n_cmp++;
        if (low_seen != 0) begin
            n_err++;
            $display("FAIL glitch_reject: sda_f went low = %0d, required 0", low_seen);
        end
        // 4-cycle low pulse: passes, forming a START then a STOP
        c0        = cyc;
        sda_pad_i = 1'b0;
        fall_cyc  = -1;
        exp_q.push_back('{1, c0 + 7});
        exp_q.push_back('{2, c0 + 11});
        for (int i = 1; i <= 18; i++) begin
            step(1);
            if (!sda_f && fall_cyc < 0) fall_cyc = cyc;
            if (i == 4) sda_pad_i = 1'b1;
        end
        n_cmp++;
        if (fall_cyc !== c0 + 6) begin
            n_err++;
            $display("FAIL glitch_latency: sda_f fell at cycle %0d, required %0d", fall_cyc, c0 + 6);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL glitch_pulse: kind %0d missing, required at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL glitch_pulse: kind %0d at %0d, required kind %0d at %0d",
                             o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_extra: %0d unexpected pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_start_stop;
        ev_t e, o;
        filt_len = '0;
        exp_q.delete();
        obs_q.delete();
        step(4);
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        n_cmp++;
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: bus_busy %b, required 1", bus_busy);
        end
        exp_q.push_back('{2, cyc + 4});
        sda_pad_i = 1'b1;
        step(6);
        n_cmp++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL stop_busy: bus_busy %b, required 0", bus_busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL startstop_pulse: kind %0d missing, required at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL startstop_pulse: kind %0d at %0d, required kind %0d at %0d",
                             o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL startstop_extra: %0d unexpected pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_repeated_start;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        scl_pad_i = 1'b0;
        step(4);
        sda_pad_i = 1'b1;
        step(4);
        scl_pad_i = 1'b1;
        step(4);
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        n_cmp++;
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstart_busy: bus_busy %b, required 1", bus_busy);
        end
        exp_q.push_back('{2, cyc + 4});
        sda_pad_i = 1'b1;
        step(6);
        n_cmp++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstart_stop_busy: bus_busy %b, required 0", bus_busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL rstart_pulse: kind %0d missing, required at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL rstart_pulse: kind %0d at %0d, required kind %0d at %0d",
                             o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL rstart_extra: %0d unexpected pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_simultaneous;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        // Idle bus: both lines fall together -> no START
        scl_pad_i = 1'b0;
        sda_pad_i = 1'b0;
        step(8);
        n_cmp++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL simul_idle_busy: bus_busy %b, required 0", bus_busy);
        end
        scl_pad_i = 1'b1;
        sda_pad_i = 1'b1;
        step(8);
        // Busy bus: SCL falls and SDA rises together -> no STOP
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        scl_pad_i = 1'b0;
        sda_pad_i = 1'b1;
        step(8);
        n_cmp++;
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL simul_busy_kept: bus_busy %b, required 1", bus_busy);
        end
        sda_pad_i = 1'b0;
        step(4);
        scl_pad_i = 1'b1;
        step(4);
        exp_q.push_back('{2, cyc + 4});
        sda_pad_i = 1'b1;
        step(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL simul_pulse: kind %0d missing, required at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL simul_pulse: kind %0d at %0d, required kind %0d at %0d",
                             o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL simul_extra: %0d unexpected pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_timeout;
        ev_t e, o;
        int  d0, r0, first_stuck, busy_at, busy_prev, last_busy, stuck_seen;
        exp_q.delete();
        obs_q.delete();
`ifdef I2C_TIMEOUT_EN
        tmo_limit = 16'd100;
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        d0          = cyc;
        scl_pad_i   = 1'b0;
        first_stuck = -1;
        busy_at     = -1;
        busy_prev   = -1;
        last_busy   = int'(bus_busy);
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (scl_stuck && first_stuck < 0) begin
                first_stuck = cyc;
                busy_at     = int'(bus_busy);
                busy_prev   = last_busy;
            end
            last_busy = int'(bus_busy);
        end
        // scl_f falls 3 edges after the pad; stuck 100 edges after that
        n_cmp++;
        if (first_stuck !== d0 + 103) begin
            n_err++;
            $display("FAIL tmo_stuck_cycle: scl_stuck rose at %0d, required %0d", first_stuck, d0 + 103);
        end
        n_cmp++;
        if (busy_at !== 0 || busy_prev !== 1) begin
            n_err++;
            $display("FAIL tmo_busy_drop: busy before/at %0d/%0d, required 1/0", busy_prev, busy_at);
        end
        n_cmp++;
        if (scl_stuck !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_sticky: scl_stuck %b, required 1", scl_stuck);
        end
        r0        = cyc;
        scl_pad_i = 1'b1;
        step(3);
        n_cmp++;
        if (scl_stuck !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_hold: scl_stuck %b at %0d, required 1", scl_stuck, r0 + 3);
        end
        step(1);
        n_cmp++;
        if (scl_stuck !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_release: scl_stuck %b at %0d, required 0", scl_stuck, r0 + 4);
        end
        exp_q.push_back('{2, cyc + 4});
        sda_pad_i = 1'b1;
        step(6);
        tmo_limit = '0;
`else
        tmo_limit = 16'd100;
`endif
        // Disabled timeout: SCL held low for a long time while busy
        exp_q.push_back('{1, cyc + 4});
        sda_pad_i = 1'b0;
        step(6);
        scl_pad_i  = 1'b0;
        stuck_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (scl_stuck) stuck_seen = 1;
        end
        n_cmp++;
        if (stuck_seen != 0 || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_disabled: stuck seen %0d busy %b, required 0 and 1", stuck_seen, bus_busy);
        end
        scl_pad_i = 1'b1;
        step(4);
        exp_q.push_back('{2, cyc + 4});
        sda_pad_i = 1'b1;
        step(6);
        n_cmp++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_final_busy: bus_busy %b, required 0", bus_busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL tmo_pulse: kind %0d missing, required at cycle %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL tmo_pulse: kind %0d at %0d, required kind %0d at %0d",
                             o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL tmo_extra: %0d unexpected pulses, required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_glitch_filter();
        test_start_stop();
        test_repeated_start();
        test_simultaneous();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_pin_conditioner.md
Name: i2c_pin_conditioner

Overview:
- Upstream front end for the APB-attached I2C master core. Sits between the raw SCL/SDA pad inputs and the core's scl_i/sda_i.
- Functions:
  - synchronises both lines into the PCLK domain;
  - removes spikes with a programmable digital glitch filter;
  - detects START/STOP conditions and tracks bus-busy;
  - optionally flags an SCL-stuck-low timeout.
- Outputs are intended to feed the core and the wrapper's RIS/IM interrupt logic.

Parameters:
- FILT_W, 4: width of the filter length field and of the per-line filter counters.
- TMO_W, 16: width of the timeout limit and the timeout counter.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- scl_pad_i  in  1  raw SCL pad input, asynchronous.
- sda_pad_i  in  1  raw SDA pad input, asynchronous.
- filt_len  in  FILT_W  glitch-filter length in PCLK cycles. 0 = minimum filtering.
- tmo_limit  in  TMO_W  SCL-low timeout in PCLK cycles. 0 = timeout disabled.
- scl_f  out  1  filtered SCL, to core scl_i.
- sda_f  out  1  filtered SDA, to core sda_i.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  high between START and STOP.
- scl_stuck  out  1  SCL held low past tmo_limit while busy.

Behaviour:
- Reset: PRESETn asynchronous, active-low; clock PCLK. While reset is asserted:
  - all synchroniser flops, scl_f and sda_f = 1 (idle bus high);
  - filter counters = 0;
  - start_det, stop_det, bus_busy, scl_stuck = 0;
  - timeout counter = 0.
- Synchroniser: 2-flop chain per line, reset value 1. Edge-history register also resets to 1, so no false edges come out of reset.
- Glitch filter, per line: counter cnt and output register f.
  - If sync == f: cnt <= 0.
  - If sync != f and cnt >= filt_len: f <= sync, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
  - The ">=" compare makes a filt_len change mid-count take effect immediately and safely.
  - A pulse lasting <= filt_len cycles at the sync output is rejected. A pulse of filt_len+1 cycles passes.
  - Pad-to-output latency: filt_len + 3 PCLK cycles (2 sync + filt_len + 1).
- Condition detect: uses registered previous values scl_q and sda_q of scl_f and sda_f.
  - START: sda_q=1, sda_f=0, scl_q=1, scl_f=1.
  - STOP: sda_q=0, sda_f=1, scl_q=1, scl_f=1.
  - Both detect outputs are registered. The pulse appears 1 cycle after the sda_f change and lasts exactly 1 cycle.
  - If SCL and SDA change in the same cycle, no condition is detected.
- bus_busy: set by start_det, cleared by stop_det. A repeated START keeps it set. Also cleared by a timeout event (see Optional Feature).
- start_det and stop_det are never asserted together.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - The TMO_W counter increments each cycle while bus_busy=1, scl_f=0 and tmo_limit!=0, saturating at tmo_limit.
  - The counter clears whenever scl_f=1 or bus_busy=0.
  - When the count reaches tmo_limit: scl_stuck <= 1 (sticky) and bus_busy <= 0 in the same cycle. The condition is checked on the same edge as the count update.
  - scl_stuck clears on the first cycle scl_f=1.
  - tmo_limit=0 disables the function: counter stays 0 and scl_stuck stays 0.
- Not defined:
  - No counter is implemented and scl_stuck is tied 0.
  - tmo_limit is still a port but is ignored.
  - bus_busy is cleared only by STOP.

Test Plan:
- Reset release with pads at 1 -> scl_f=sda_f=1; start_det, stop_det, bus_busy, scl_stuck all 0; no pulses during the first 10 cycles.
- filt_len=3:
  - 3-cycle low glitch on sda_pad_i with SCL high -> sda_f stays 1, no start_det.
  - 4-cycle low pulse -> sda_f falls 6 cycles after the pad edge.
- filt_len=0, SCL high, SDA 1->0 -> start_det single pulse, bus_busy=1. Then SDA 0->1 -> stop_det single pulse, bus_busy=0.
- Repeated START: START, SCL low, SDA high, SCL high, SDA low -> second start_det pulse, bus_busy remains 1, no stop_det.
- SCL and SDA driven low on the same PCLK edge -> no start_det, bus_busy unchanged.
- I2C_TIMEOUT_EN defined, tmo_limit=100, START then SCL held low -> scl_stuck=1 and bus_busy=0 at the 100th low cycle. SCL released -> scl_stuck=0. tmo_limit=0 -> scl_stuck never asserts.
